button_debounce: RTL and testbench



---
 rtl/button_debounce.sv | 172 +++++++++++++++++
 tb/tb_button_debounce.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// button_debounce
//   Conditions raw active-low board buttons for the control block. Each bit
//   is synchronised into clk with two flops, then debounced by its own FSM.
//   Outputs are registered, active-high levels plus one-cycle event pulses.
//
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   button_n    : raw buttons, 0 = pressed, idle 1
//   btn_level   : debounced state, 1 = pressed
//   btn_press   : one-cycle pulse on an accepted press
//   btn_release : one-cycle pulse on an accepted release
//   btn_long    : one-cycle pulse once per hold reaching LONG_PRESS_CYCLES
module button_debounce #(
  parameter int NUM_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES   = 270000,
  parameter int LONG_PRESS_CYCLES = 27000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] button_n,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  output logic [NUM_BUTTONS-1:0] btn_long
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_PRESS_CYCLES);
  localparam logic [LW-1:0] LONG_PRE = LW'(LONG_PRESS_CYCLES - 1);
  localparam logic [LW-1:0] LONG_ONE = LW'(1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } state_e;

  logic [NUM_BUTTONS-1:0] sync1_q, sync1_d;
  logic [NUM_BUTTONS-1:0] sync2_q, sync2_d;
  logic [NUM_BUTTONS-1:0] s;

  state_e        state_q [NUM_BUTTONS];
  state_e        state_d [NUM_BUTTONS];
  logic [CW-1:0] cnt_q   [NUM_BUTTONS];
  logic [CW-1:0] cnt_d   [NUM_BUTTONS];
  logic [LW-1:0] long_q  [NUM_BUTTONS];
  logic [LW-1:0] long_d  [NUM_BUTTONS];

  logic [NUM_BUTTONS-1:0] level_q,   level_d;
  logic [NUM_BUTTONS-1:0] press_q,   press_d;
  logic [NUM_BUTTONS-1:0] release_q, release_d;
  logic [NUM_BUTTONS-1:0] lpulse_q,  lpulse_d;

  assign sync1_d = button_n;
  assign sync2_d = sync1_q;
  assign s       = ~sync2_q;

  // State register (synchroniser, FSMs, counters, registered outputs)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      lpulse_q  <= '0;
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
        long_q[i]  <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      lpulse_q  <= lpulse_d;
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        long_q[i]  <= long_d[i];
      end
    end
  end

  // Next-state logic, one FSM per button
  always_comb begin
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      long_d[i]  = long_q[i];
      unique case (state_q[i])
        RELEASED: begin
          long_d[i] = '0;
          cnt_d[i]  = '0;
          if (s[i]) begin
            state_d[i] = PRESS_CHK;
            cnt_d[i]   = CNT_ONE;
          end
        end
        PRESS_CHK: begin
          if (!s[i]) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_MAX) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
            long_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (long_q[i] != LONG_MAX) long_d[i] = long_q[i] + LONG_ONE;
          if (!s[i]) begin
            state_d[i] = RELEASE_CHK;
            cnt_d[i]   = CNT_ONE;
          end
        end
        RELEASE_CHK: begin
          // Hold time keeps accumulating while a release is being qualified
          if (long_q[i] != LONG_MAX) long_d[i] = long_q[i] + LONG_ONE;
          if (s[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_MAX) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
            long_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = RELEASED;
          cnt_d[i]   = '0;
          long_d[i]  = '0;
        end
      endcase
    end
  end

  // Output logic: decoded from the transition so the flops present it
  // on the same edge the FSM changes state
  always_comb begin
    level_d   = '0;
    press_d   = '0;
    release_d = '0;
    lpulse_d  = '0;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      level_d[i]   = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_CHK);
      press_d[i]   = (state_q[i] == PRESS_CHK) && (state_d[i] == PRESSED);
      release_d[i] = (state_q[i] == RELEASE_CHK) && (state_d[i] == RELEASED);
      // Only the step into saturation fires, so one pulse per hold
      lpulse_d[i]  = ((state_q[i] == PRESSED) || (state_q[i] == RELEASE_CHK)) &&
                     (long_q[i] == LONG_PRE) && (long_d[i] == LONG_MAX);
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = lpulse_q;

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  localparam int N  = 2;
  localparam int DB = 3;
  localparam int LP = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] button_n = 2'b11;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

  int tests = 0;
  int fails = 0;

  button_debounce #(
    .NUM_BUTTONS      (N),
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button_n   (button_n),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         grp;
    logic [1:0] bn;
    logic [1:0] lvl;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] lg;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int grp, input logic [1:0] bn, input logic [1:0] lvl,
                              input logic [1:0] pr, input logic [1:0] rl, input logic [1:0] lg);
    vec_t v;
    v.grp = grp; v.bn = bn; v.lvl = lvl; v.pr = pr; v.rl = rl; v.lg = lg;
    vecs.push_back(v);
  endfunction

  // Compares {level, press, release, long}
  task automatic chk(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {btn_level, btn_press, btn_release, btn_long};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got lvl/pr/rl/lg=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int bounce[14];
    string nm;
    bounce = '{0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1};

    // 1: idle after reset
    for (int j = 1; j <= 10; j++) add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    // 2: press/release bit 0, event on edge 6 of each phase
    for (int j = 1; j <= 10; j++)
      add(2, 2'b10, (j >= 6) ? 2'b01 : 2'b00, (j == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00);
    for (int j = 1; j <= 10; j++)
      add(2, 2'b11, (j < 6) ? 2'b01 : 2'b00, 2'b00, (j == 6) ? 2'b01 : 2'b00, 2'b00);
    // 3: short pulse and bounce train on bit 1, nothing must happen
    for (int j = 1; j <= 10; j++)
      add(3, (j <= 3) ? 2'b01 : 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int j = 0; j < 14; j++)
      add(3, (bounce[j] == 0) ? 2'b01 : 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int j = 1; j <= 4; j++) add(3, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    // 4: long hold on bit 1, long pulse 20 edges after press
    for (int j = 1; j <= 40; j++)
      add(4, 2'b01, (j >= 6) ? 2'b10 : 2'b00, (j == 6) ? 2'b10 : 2'b00, 2'b00,
          (j == 26) ? 2'b10 : 2'b00);
    for (int j = 1; j <= 10; j++)
      add(4, 2'b11, (j < 6) ? 2'b10 : 2'b00, 2'b00, (j == 6) ? 2'b10 : 2'b00, 2'b00);
    // 5: simultaneous press on both bits
    for (int j = 1; j <= 10; j++)
      add(5, 2'b00, (j >= 6) ? 2'b11 : 2'b00, (j == 6) ? 2'b11 : 2'b00, 2'b00, 2'b00);
    for (int j = 1; j <= 10; j++)
      add(5, 2'b11, (j < 6) ? 2'b11 : 2'b00, 2'b00, (j == 6) ? 2'b11 : 2'b00, 2'b00);

    // Reset
    #1 rst_n = 1'b0;
    #1 chk("reset_async", 8'h00);
    repeat (3) @(posedge clk);
    #1 chk("reset_held", 8'h00);
    @(negedge clk) rst_n = 1'b1;

    // Table-driven section
    foreach (vecs[k]) begin
      button_n = vecs[k].bn;
      @(posedge clk);
      #1;
      nm = $sformatf("vec%0d_grp%0d", k, vecs[k].grp);
      chk(nm, {vecs[k].lvl, vecs[k].pr, vecs[k].rl, vecs[k].lg});
    end

    // 6: reset during PRESS_CHK of bit 0 while bit 1 is pressed
    button_n = 2'b01;
    repeat (8) @(posedge clk);
    #1 chk("t6_bit1_pressed", {2'b10, 2'b00, 2'b00, 2'b00});
    button_n = 2'b00;
    repeat (4) @(posedge clk);
    #1 chk("t6_bit0_in_check", {2'b10, 2'b00, 2'b00, 2'b00});
    #2 rst_n = 1'b0;
    #1 chk("t6_reset_immediate", 8'h00);
    button_n = 2'b10;
    @(posedge clk);
    #1 chk("t6_reset_hold", 8'h00);
    @(negedge clk) rst_n = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk);
      #1;
      nm = $sformatf("t6_fresh_press_e%0d", j);
      chk(nm, {(j >= 6) ? 2'b01 : 2'b00, (j == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00});
    end
    // Two-cycle high bounce while pressed must not release
    button_n = 2'b11;
    repeat (2) @(posedge clk);
    button_n = 2'b10;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk);
      #1;
      nm = $sformatf("t6_bounce_e%0d", j);
      chk(nm, {2'b01, 2'b00, 2'b00, 2'b00});
    end
    // Real release; hold time reaches 20 while qualifying the release
    button_n = 2'b11;
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk);
      #1;
      nm = $sformatf("t6_release_e%0d", j);
      chk(nm, {(j < 6) ? 2'b01 : 2'b00, 2'b00, (j == 6) ? 2'b01 : 2'b00,
               (j == 4) ? 2'b01 : 2'b00});
    end
    repeat (3) @(posedge clk);
    #1 chk("t6_idle_end", 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
